// File: rtl/leaf_out_arbiter_if.sv
// Stream bundle between the user words, the arbiter and the BFT output port.
// The arbiter sits on the slave side; the environment drives the master side.
interface leaf_out_arbiter_if #(
  parameter int NUM_OUT_PORTS = 2,
  parameter int PAYLOAD_BITS  = 32,
  parameter int PACKET_BITS   = 49
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
  logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;
  logic                                  dout_accept;
  logic                                  resend;

  modport master (
    output din_leaf_user2interface,
    output vld_user2interface,
    output dout_accept,
    output resend,
    input  ack_interface2user,
    input  dout_leaf_interface2bft
  );

  modport slave (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    input  dout_accept,
    input  resend,
    output ack_interface2user,
    output dout_leaf_interface2bft
  );
endinterface

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter packing user words into BFT packets, gated by a
// per-port destination table and per-port freespace credits.
//
// state | meaning
// IDLE  | no packet held, output is all zeros
// HOLD  | packet held on the output until the BFT accepts it
module leaf_out_arbiter #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 2,
  parameter int CREDIT_BITS           = 8,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int INIT_CREDITS          = 64,
  localparam int PORT_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  leaf_out_arbiter_if.slave        bus,
  input  logic                     cfg_wr,
  input  logic [PORT_W-1:0]        cfg_port,
  input  logic [NUM_LEAF_BITS-1:0] cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dport,
  input  logic [NUM_OUT_PORTS-1:0] credit_upd
);

  localparam int CREDIT_MAX = (1 << CREDIT_BITS) - 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state_q, state_d;

  logic [NUM_OUT_PORTS-1:0]                    cfg_valid_q;
  logic [NUM_OUT_PORTS-1:0][NUM_LEAF_BITS-1:0] leaf_q;
  logic [NUM_OUT_PORTS-1:0][NUM_PORT_BITS-1:0] dport_q;
  logic [NUM_OUT_PORTS-1:0][NUM_ADDR_BITS-1:0] seq_q;
  logic [NUM_OUT_PORTS-1:0][CREDIT_BITS-1:0]   credit_q, credit_d;
  logic [PORT_W-1:0]                           last_grant_q;
  logic [PACKET_BITS-1:0]                      pkt_q, pkt_d;
  logic [NUM_OUT_PORTS-1:0]                    ack_q;

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] grant_oh;
  logic                     grant_any;
  logic [PORT_W-1:0]        grant_idx;
  logic                     arb_en;

  // Arbitrate when the output register is free now or frees up this cycle.
  assign arb_en = (state_q == IDLE) || bus.dout_accept;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = bus.vld_user2interface[i] && cfg_valid_q[i] &&
                    (credit_q[i] != '0) && !bus.resend;
    end
  end

  always_comb begin
    int          idx;
    logic [PORT_W-1:0] idx_p;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    idx       = 0;
    idx_p     = '0;
    for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_OUT_PORTS) idx = idx - NUM_OUT_PORTS;
      idx_p = idx[PORT_W-1:0];
      if (arb_en && !grant_any && eligible[idx_p]) begin
        grant_any       = 1'b1;
        grant_idx       = idx_p;
        grant_oh[idx_p] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    if (grant_any) begin
      state_d = HOLD;
      pkt_d   = {1'b1, leaf_q[grant_idx], dport_q[grant_idx], seq_q[grant_idx],
                 bus.din_leaf_user2interface[int'(grant_idx)*PAYLOAD_BITS +: PAYLOAD_BITS]};
    end else if (arb_en) begin
      state_d = IDLE;
      pkt_d   = '0;
    end
  end

  // Net credit change with saturation; a grant never sees a zero counter.
  always_comb begin
    int tmp;
    tmp      = 0;
    credit_d = credit_q;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      tmp = int'(credit_q[i]);
      if (credit_upd[i]) tmp = tmp + FREESPACE_UPDATE_SIZE;
      if (grant_oh[i])   tmp = tmp - 1;
      if (tmp > CREDIT_MAX) credit_d[i] = CREDIT_BITS'(CREDIT_MAX);
      else                  credit_d[i] = CREDIT_BITS'(tmp);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_q        <= '0;
      ack_q        <= '0;
      last_grant_q <= PORT_W'(NUM_OUT_PORTS - 1);
      cfg_valid_q  <= '0;
      leaf_q       <= '0;
      dport_q      <= '0;
      seq_q        <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) credit_q[i] <= CREDIT_BITS'(INIT_CREDITS);
    end else begin
      pkt_q    <= pkt_d;
      ack_q    <= grant_oh;
      credit_q <= credit_d;
      if (grant_any) last_grant_q <= grant_idx;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (grant_oh[i]) seq_q[i] <= seq_q[i] + 1'b1;
      end
      // Table writes land after this cycle's grant, so held packets keep old fields.
      if (cfg_wr && (int'(cfg_port) < NUM_OUT_PORTS)) begin
        leaf_q[cfg_port]      <= cfg_leaf;
        dport_q[cfg_port]     <= cfg_dport;
        cfg_valid_q[cfg_port] <= 1'b1;
      end
    end
  end

  assign bus.dout_leaf_interface2bft = pkt_q;
  assign bus.ack_interface2user      = ack_q;

endmodule
